// File: rtl/loader_pkg.sv
// Shared constants and state encodings for the RAM boot loader and its
// serial byte receiver.
package loader_pkg;

  localparam int unsigned DEFAULT_CLKS_PER_BIT = 434;
  localparam logic [15:0] DEFAULT_BASE_ADDR    = 16'h0000;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

  typedef enum logic [2:0] {
    LD_CNT_HI,
    LD_CNT_LO,
    LD_DAT_HI,
    LD_DAT_LO,
    LD_WRITE,
    LD_DONE
  } ld_state_t;

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 serial byte receiver: rx synchroniser, baud counter and byte FSM.
// byte_valid / stop_err are single-cycle strobes raised at the stop-bit sample.
module uart_rx_byte
  import loader_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] byte_data,
  output logic       byte_valid,
  output logic       stop_err
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_LAST = CW'(CLKS_PER_BIT - 1);

  logic          rx_meta;
  logic          rx_sync;
  rx_state_t     state;
  rx_state_t     next_state;
  logic [CW-1:0] baud_cnt;
  logic [2:0]    bit_idx;
  logic          sample;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
    end
  end

  // Start bit is resampled at its midpoint; every later sample is a full bit on.
  always_comb begin
    sample = 1'b0;
    case (state)
      RX_START:         sample = (baud_cnt == HALF_LAST);
      RX_DATA, RX_STOP: sample = (baud_cnt == FULL_LAST);
      default:          sample = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= RX_IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      RX_IDLE:  if (!rx_sync) next_state = RX_START;
      RX_START: if (sample) next_state = rx_sync ? RX_IDLE : RX_DATA;
      RX_DATA:  if (sample && bit_idx == 3'd7) next_state = RX_STOP;
      RX_STOP:  if (sample) next_state = RX_IDLE;
      default:  next_state = RX_IDLE;
    endcase
  end

  always_comb begin
    byte_valid = (state == RX_STOP) && sample && rx_sync;
    stop_err   = (state == RX_STOP) && sample && !rx_sync;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      baud_cnt  <= '0;
      bit_idx   <= '0;
      byte_data <= '0;
    end else begin
      if (state == RX_IDLE || sample) baud_cnt <= '0;
      else                            baud_cnt <= baud_cnt + 1'b1;

      if (state != RX_DATA) bit_idx <= '0;
      else if (sample)      bit_idx <= bit_idx + 3'd1;

      // LSB arrives first, so shift in from the top.
      if (state == RX_DATA && sample) byte_data <= {rx_sync, byte_data[7:1]};
    end
  end

endmodule

// File: rtl/ram_loader.sv
// Boot-time program loader: receives a big-endian [count, words...] image over
// serial and writes it to RAM from BASE_ADDR while holding the CPU in reset.
module ram_loader
  import loader_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter logic [15:0] BASE_ADDR    = DEFAULT_BASE_ADDR
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx,
  input  logic        start,
  output logic        cpu_hold,
  output logic [15:0] ram_address,
  output logic [15:0] ram_data,
  output logic        ram_wren,
  output logic        load_done,
  output logic        frame_err,
  output logic [15:0] word_count
);

  logic [7:0]  byte_data;
  logic        byte_valid;
  logic        stop_err;
  ld_state_t   state;
  ld_state_t   next_state;
  logic [7:0]  hi_byte;
  logic [15:0] word_total;
  logic        abort;

  uart_rx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .byte_data (byte_data),
    .byte_valid(byte_valid),
    .stop_err  (stop_err)
  );

  // A framing error restarts the image, except once loading is finished.
  always_comb abort = stop_err && (state != LD_DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= LD_CNT_HI;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    if (start || abort) begin
      next_state = LD_CNT_HI;
    end else begin
      case (state)
        LD_CNT_HI: if (byte_valid) next_state = LD_CNT_LO;
        LD_CNT_LO: if (byte_valid)
                     next_state = ({hi_byte, byte_data} == 16'h0000) ? LD_DONE : LD_DAT_HI;
        LD_DAT_HI: if (byte_valid) next_state = LD_DAT_LO;
        LD_DAT_LO: if (byte_valid) next_state = LD_WRITE;
        LD_WRITE:  next_state = (word_count + 16'd1 == word_total) ? LD_DONE : LD_DAT_HI;
        LD_DONE:   next_state = LD_DONE;
        default:   next_state = LD_CNT_HI;
      endcase
    end
  end

  always_comb ram_wren = (state == LD_WRITE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cpu_hold    <= 1'b1;
      load_done   <= 1'b0;
      frame_err   <= 1'b0;
      ram_address <= BASE_ADDR;
      ram_data    <= '0;
      word_count  <= '0;
      hi_byte     <= '0;
      word_total  <= '0;
    end else begin
      // Registered from next_state so the done pulse and hold release coincide.
      load_done <= (next_state == LD_DONE) && (state != LD_DONE);
      cpu_hold  <= (next_state != LD_DONE);

      if (start) begin
        frame_err   <= 1'b0;
        ram_address <= BASE_ADDR;
        word_count  <= '0;
      end else if (abort) begin
        frame_err   <= 1'b1;
        ram_address <= BASE_ADDR;
        word_count  <= '0;
      end else begin
        if (stop_err) frame_err <= 1'b1;
        case (state)
          LD_CNT_HI, LD_DAT_HI: if (byte_valid) hi_byte <= byte_data;
          LD_CNT_LO:            if (byte_valid) word_total <= {hi_byte, byte_data};
          LD_DAT_LO:            if (byte_valid) ram_data <= {hi_byte, byte_data};
          LD_WRITE: begin
            ram_address <= ram_address + 16'd1;
            word_count  <= word_count + 16'd1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule
